armored66_lane_lock: RTL and testbench

//  Parametrised per-lane word-lock and 33-bit half-word framing controller for the armored66 RX path.

---
 rtl/armored66_lane_lock.sv | 208 ++++++++++++++++++++
 tb/tb_armored66_lane_lock.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armored66_lane_lock.sv
// armored66_lane_lock
//   Per-lane word-lock and 33-bit half-word framing controller for the
//   armored66 RX path. Each lane hunts for word alignment by watching ECC
//   error flags over fixed observation windows. It issues transceiver bitslips
//   until it sees LOCK_WINS clean windows in a row, and then polices frame
//   headers to correct the 33-bit half-word phase with FIFO half-slips.
//
// Ports
//   clk           recovered core clock (dout_clk domain)
//   arst          asynchronous reset, active high
//   din_valid     shared strobe, din holds a complete 66-bit word per lane
//   din           assembled words, lane i = din[i*66 +: 66]
//   dec_fix       per-lane ECC corrected-error flag
//   dec_fail      per-lane ECC uncorrected-error flag
//   clr_stats     synchronous clear of err_cnt and slip_timeout
//   bitslip       per-lane one-cycle pulse, slip transceiver one bit
//   half_slip     per-lane one-cycle pulse, drop one FIFO read
//   wordlock      per-lane locked status
//   all_locked    registered AND of wordlock
//   slip_timeout  per-lane sticky flag, SLIP_LIMIT slips without lock
//   err_cnt       per-lane saturating ECC error count while locked
//
// state   | meaning
// FLUSH   | discard errors from the window after a slip or unlock
// OBSERVE | first qualification window, any error forces a bitslip
// PEND    | further clean windows needed before lock is declared
// LOCKED  | word-locked, frame checks active, unlock on error burst
module armored66_lane_lock #(
  parameter int NUM_LN      = 4,
  parameter int WIN_LOG2    = 6,
  parameter int UNLOCK_ERRS = 8,
  parameter int LOCK_WINS   = 2,
  parameter int SLIP_LIMIT  = 80,
  parameter int FE_ERRS     = 2,
  parameter int GRACE       = 64
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 din_valid,
  input  logic [NUM_LN*66-1:0] din,
  input  logic [NUM_LN-1:0]    dec_fix,
  input  logic [NUM_LN-1:0]    dec_fail,
  input  logic                 clr_stats,
  output logic [NUM_LN-1:0]    bitslip,
  output logic [NUM_LN-1:0]    half_slip,
  output logic [NUM_LN-1:0]    wordlock,
  output logic                 all_locked,
  output logic [NUM_LN-1:0]    slip_timeout,
  output logic [NUM_LN*16-1:0] err_cnt
);

  localparam int WCW = $clog2(UNLOCK_ERRS + 2);
  localparam int CLW = $clog2(LOCK_WINS + 1);
  localparam int SCW = $clog2(SLIP_LIMIT + 1);
  localparam int FEW = $clog2(FE_ERRS + 1);
  localparam int GRW = (GRACE > 0) ? $clog2(GRACE + 1) : 1;

  localparam logic [WCW-1:0] UNLOCK_V  = WCW'(UNLOCK_ERRS);
  localparam logic [CLW-1:0] LOCKW_V   = CLW'(LOCK_WINS);
  localparam logic [SCW-1:0] SLIP_LAST = SCW'(SLIP_LIMIT - 1);
  localparam logic [FEW-1:0] FE_V      = FEW'(FE_ERRS);
  localparam logic [GRW-1:0] GRACE_V   = GRW'(GRACE);

  typedef enum logic [1:0] {
    FLUSH   = 2'd0,
    OBSERVE = 2'd1,
    PEND    = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  state_t           state    [NUM_LN];
  logic [WCW-1:0]   wcnt     [NUM_LN];
  logic [CLW-1:0]   clean    [NUM_LN];
  logic [SCW-1:0]   slip_cnt [NUM_LN];
  logic [FEW-1:0]   fe_cnt   [NUM_LN];
  logic [GRW-1:0]   grace    [NUM_LN];

  logic [WIN_LOG2-1:0] cnt;
  logic                ping;
  logic [NUM_LN-1:0]   err;
  logic [NUM_LN-1:0]   unlock;
  logic [NUM_LN-1:0]   slip_req;
  logic [NUM_LN-1:0]   bad;
  logic [WCW-1:0]      wsum [NUM_LN];

  // Only the sync header and control-type bits are inspected; the payload is
  // folded here so it is visibly consumed.
  logic unused_din;
  assign unused_din = ^din;

  always_comb begin
    ping = &cnt;
    for (int i = 0; i < NUM_LN; i++) begin
      err[i]      = dec_fix[i] | dec_fail[i];
      // Running window total including this cycle's error.
      wsum[i]     = wcnt[i] + WCW'(err[i]);
      bad[i]      = (din[i*66 +: 2] == 2'b00) || (din[i*66 +: 2] == 2'b11) ||
                    (din[i*66] && (^din[i*66+34 +: 4]));
      unlock[i]   = (state[i] == LOCKED) && (wsum[i] >= UNLOCK_V);
      slip_req[i] = ping && (wsum[i] != '0) &&
                    ((state[i] == OBSERVE) || (state[i] == PEND));
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt          <= '0;
      all_locked   <= 1'b0;
      bitslip      <= '0;
      half_slip    <= '0;
      wordlock     <= '0;
      slip_timeout <= '0;
      err_cnt      <= '0;
      for (int i = 0; i < NUM_LN; i++) begin
        state[i]    <= FLUSH;
        wcnt[i]     <= '0;
        clean[i]    <= '0;
        slip_cnt[i] <= '0;
        fe_cnt[i]   <= '0;
        grace[i]    <= '0;
      end
    end else begin
      cnt        <= cnt + WIN_LOG2'(1);
      all_locked <= &wordlock;
      for (int i = 0; i < NUM_LN; i++) begin
        bitslip[i]   <= 1'b0;
        half_slip[i] <= 1'b0;

        wcnt[i] <= ping ? WCW'(err[i]) : ((wsum[i] >= UNLOCK_V) ? UNLOCK_V : wsum[i]);

        if (clr_stats)
          err_cnt[i*16 +: 16] <= 16'h0000;
        else if ((state[i] == LOCKED) && err[i] && (err_cnt[i*16 +: 16] != 16'hFFFF))
          err_cnt[i*16 +: 16] <= err_cnt[i*16 +: 16] + 16'd1;

        // A timeout set in the same cycle overrides this clear below.
        if (clr_stats)
          slip_timeout[i] <= 1'b0;

        if (slip_req[i]) begin
          bitslip[i] <= 1'b1;
          if (slip_cnt[i] == SLIP_LAST) begin
            slip_cnt[i]     <= '0;
            slip_timeout[i] <= 1'b1;
          end else begin
            slip_cnt[i] <= slip_cnt[i] + SCW'(1);
          end
        end else if (state[i] == LOCKED) begin
          slip_cnt[i] <= '0;
        end

        case (state[i])
          FLUSH: begin
            if (ping)
              state[i] <= OBSERVE;
          end
          OBSERVE: begin
            if (slip_req[i]) begin
              state[i] <= FLUSH;
            end else if (ping) begin
              clean[i] <= CLW'(1);
              if (LOCK_WINS == 1) begin
                state[i]    <= LOCKED;
                wordlock[i] <= 1'b1;
              end else begin
                state[i] <= PEND;
              end
            end
          end
          PEND: begin
            if (slip_req[i]) begin
              state[i] <= FLUSH;
            end else if (ping) begin
              clean[i] <= clean[i] + CLW'(1);
              if ((clean[i] + CLW'(1)) == LOCKW_V) begin
                state[i]    <= LOCKED;
                wordlock[i] <= 1'b1;
              end
            end
          end
          default: begin
            if (unlock[i]) begin
              // Unlock takes priority over any pending half-slip.
              state[i]    <= FLUSH;
              wordlock[i] <= 1'b0;
              fe_cnt[i]   <= '0;
              grace[i]    <= '0;
            end else if (grace[i] != '0) begin
              grace[i]  <= grace[i] - GRW'(1);
              fe_cnt[i] <= '0;
            end else if (din_valid) begin
              if (!bad[i]) begin
                fe_cnt[i] <= '0;
              end else if ((fe_cnt[i] + FEW'(1)) >= FE_V) begin
                half_slip[i] <= 1'b1;
                fe_cnt[i]    <= '0;
                grace[i]     <= GRACE_V;
              end else begin
                fe_cnt[i] <= fe_cnt[i] + FEW'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_armored66_lane_lock.sv
module tb_armored66_lane_lock;

  localparam int NL          = 4;
  localparam int WIN         = 64;
  localparam int UNLOCK_ERRS = 8;
  localparam int LOCK_WINS   = 2;
  localparam int SLIP_LIMIT  = 80;
  localparam int FE_ERRS     = 2;
  localparam int GRACE       = 64;

  localparam int S_FLUSH = 0;
  localparam int S_OBS   = 1;
  localparam int S_PEND  = 2;
  localparam int S_LOCK  = 3;

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              din_valid = 1'b0;
  logic [NL*66-1:0]  din = '0;
  logic [NL-1:0]     dec_fix = '0;
  logic [NL-1:0]     dec_fail = '0;
  logic              clr_stats = 1'b0;
  logic [NL-1:0]     bitslip, half_slip, wordlock, slip_timeout;
  logic              all_locked;
  logic [NL*16-1:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // behavioural reference model
  int      m_cyc;
  int      m_st    [NL];
  int      m_win   [NL];
  int      m_clean [NL];
  int      m_slips [NL];
  int      m_fe    [NL];
  int      m_grace [NL];
  int      m_errc  [NL];
  bit [NL-1:0] m_bs, m_hs, m_wl, m_to;
  bit      m_all;

  armored66_lane_lock dut (
    .clk(clk), .arst(arst), .din_valid(din_valid), .din(din),
    .dec_fix(dec_fix), .dec_fail(dec_fail), .clr_stats(clr_stats),
    .bitslip(bitslip), .half_slip(half_slip), .wordlock(wordlock),
    .all_locked(all_locked), .slip_timeout(slip_timeout), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit frame_bad(input logic [65:0] w);
    int ones;
    ones = $countones(w[37:34]);
    return (w[1:0] == 2'b00) || (w[1:0] == 2'b11) || (w[1:0] == 2'b01 && (ones % 2) == 1);
  endfunction

  function automatic logic [65:0] rand_word();
    logic [65:0] w;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[65:64] = 2'($urandom_range(0, 3));
    return w;
  endfunction

  function automatic logic [65:0] good_word();
    logic [65:0] w;
    w = rand_word();
    if ($urandom_range(0, 1) == 1) begin
      w[1:0] = 2'b10;
    end else begin
      w[1:0] = 2'b01;
      w[34]  = ^w[37:35];
    end
    return w;
  endfunction

  function automatic logic [NL*16-1:0] exp_err();
    logic [NL*16-1:0] v;
    for (int l = 0; l < NL; l++) v[l*16 +: 16] = 16'(m_errc[l]);
    return v;
  endfunction

  task automatic idle_inputs();
    din_valid = 1'b0;
    dec_fix   = '0;
    dec_fail  = '0;
    clr_stats = 1'b0;
  endtask

  task automatic model_reset();
    m_cyc = 0;
    m_bs = '0; m_hs = '0; m_wl = '0; m_to = '0; m_all = 1'b0;
    for (int l = 0; l < NL; l++) begin
      m_st[l] = S_FLUSH; m_win[l] = 0; m_clean[l] = 0; m_slips[l] = 0;
      m_fe[l] = 0; m_grace[l] = 0; m_errc[l] = 0;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    model_reset();
    arst = 1'b0;
  endtask

  // Advance one clock: update the model from the inputs of the cycle that ends
  // at this edge, then return on the following falling edge.
  task automatic tick();
    int e, tot;
    bit ping, prev_all;
    logic [65:0] w;
    @(posedge clk);
    ping = (m_cyc % WIN) == (WIN - 1);
    prev_all = (m_wl == '1);
    for (int l = 0; l < NL; l++) begin
      e   = (dec_fix[l] || dec_fail[l]) ? 1 : 0;
      tot = m_win[l] + e;
      w   = din[l*66 +: 66];
      m_bs[l] = 1'b0;
      m_hs[l] = 1'b0;
      if (clr_stats) m_errc[l] = 0;
      else if (m_st[l] == S_LOCK && e == 1 && m_errc[l] < 65535) m_errc[l]++;
      if (clr_stats) m_to[l] = 1'b0;
      case (m_st[l])
        S_FLUSH: if (ping) m_st[l] = S_OBS;
        S_OBS, S_PEND: begin
          if (ping) begin
            if (tot > 0) begin
              m_bs[l] = 1'b1;
              m_slips[l]++;
              if (m_slips[l] == SLIP_LIMIT) begin
                m_slips[l] = 0;
                m_to[l] = 1'b1;
              end
              m_st[l] = S_FLUSH;
            end else begin
              m_clean[l] = (m_st[l] == S_OBS) ? 1 : m_clean[l] + 1;
              m_st[l] = (m_clean[l] >= LOCK_WINS) ? S_LOCK : S_PEND;
            end
          end
        end
        default: begin
          m_slips[l] = 0;
          if (tot >= UNLOCK_ERRS) begin
            m_st[l] = S_FLUSH; m_fe[l] = 0; m_grace[l] = 0;
          end else if (m_grace[l] > 0) begin
            m_grace[l]--; m_fe[l] = 0;
          end else if (din_valid) begin
            if (frame_bad(w)) begin
              m_fe[l]++;
              if (m_fe[l] >= FE_ERRS) begin
                m_hs[l] = 1'b1; m_fe[l] = 0; m_grace[l] = GRACE;
              end
            end else begin
              m_fe[l] = 0;
            end
          end
        end
      endcase
      m_win[l] = ping ? e : ((tot > UNLOCK_ERRS) ? UNLOCK_ERRS : tot);
      m_wl[l]  = (m_st[l] == S_LOCK);
    end
    m_all = prev_all;
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    arst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: outputs=%h expected 0",
               {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt});
    end
    do_reset();
    n_tests++;
    if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_release: outputs=%h expected 0",
               {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt});
    end
  endtask

  task automatic test_power_up();
    logic [NL-1:0] any_bs;
    any_bs = '0;
    do_reset();
    while (m_cyc < 200) begin
      din_valid = ($urandom_range(0, 1) == 1);
      for (int l = 0; l < NL; l++) din[l*66 +: 66] = good_word();
      tick();
      any_bs |= bitslip;
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL power_up_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
      if (m_cyc == 191) begin
        n_tests++;
        if (wordlock !== 4'h0) begin n_fail++; $display("FAIL power_up_wl191: got=%h exp=0", wordlock); end
      end
      if (m_cyc == 192) begin
        n_tests++;
        if (wordlock !== 4'hF || all_locked !== 1'b0) begin
          n_fail++; $display("FAIL power_up_wl192: wl=%h all=%b exp F/0", wordlock, all_locked);
        end
      end
      if (m_cyc == 193) begin
        n_tests++;
        if (all_locked !== 1'b1) begin n_fail++; $display("FAIL power_up_all193: got=%b exp 1", all_locked); end
      end
    end
    n_tests++;
    if (any_bs !== '0) begin n_fail++; $display("FAIL power_up_no_bitslip: got=%h exp 0", any_bs); end
    idle_inputs();
  endtask

  task automatic test_observe_slip();
    int ecyc, n_bs, bs_at;
    ecyc = $urandom_range(64, 126);
    n_bs = 0; bs_at = -1;
    do_reset();
    while (m_cyc < 330) begin
      dec_fix[1] = (m_cyc == ecyc);
      tick();
      if (bitslip[1]) begin n_bs++; bs_at = m_cyc; end
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL observe_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
      if (m_cyc == 192) begin
        n_tests++;
        if (wordlock !== 4'b1101) begin n_fail++; $display("FAIL observe_wl192: got=%h exp=d", wordlock); end
      end
      if (m_cyc == 319 || m_cyc == 320) begin
        n_tests++;
        if (wordlock[1] !== (m_cyc == 320)) begin
          n_fail++; $display("FAIL observe_wl1 cyc=%0d: got=%b", m_cyc, wordlock[1]);
        end
      end
    end
    n_tests++;
    if (n_bs != 1 || bs_at != 128) begin
      n_fail++; $display("FAIL observe_bitslip: pulses=%0d at=%0d exp 1 at 128", n_bs, bs_at);
    end
    idle_inputs();
  endtask

  task automatic test_unlock_thresh();
    int ln, s1, s2;
    bit any_bs;
    logic [1:0] kind;
    ln = $urandom_range(0, NL - 1);
    s1 = $urandom_range(192, 240);
    s2 = $urandom_range(256, 300);
    any_bs = 1'b0;
    do_reset();
    while (m_cyc < s2 + 12) begin
      dec_fix = '0; dec_fail = '0;
      if ((m_cyc >= s1 && m_cyc < s1 + 7) || (m_cyc >= s2 && m_cyc < s2 + 8)) begin
        kind = 2'($urandom_range(1, 3));
        dec_fix[ln]  = kind[0];
        dec_fail[ln] = kind[1];
      end
      tick();
      if (m_cyc > 192 && bitslip !== '0) any_bs = 1'b1;
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL unlock_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
      if (m_cyc == 256) begin
        n_tests++;
        if (wordlock[ln] !== 1'b1 || err_cnt[ln*16 +: 16] !== 16'd7) begin
          n_fail++; $display("FAIL unlock_seven: wl=%b cnt=%0d exp 1/7", wordlock[ln], err_cnt[ln*16 +: 16]);
        end
      end
      if (m_cyc == s2 + 7) begin
        n_tests++;
        if (wordlock[ln] !== 1'b1) begin n_fail++; $display("FAIL unlock_early: wl=%b exp 1", wordlock[ln]); end
      end
      if (m_cyc == s2 + 8) begin
        n_tests++;
        if (wordlock[ln] !== 1'b0 || err_cnt[ln*16 +: 16] !== 16'd15) begin
          n_fail++; $display("FAIL unlock_eight: wl=%b cnt=%0d exp 0/15", wordlock[ln], err_cnt[ln*16 +: 16]);
        end
      end
    end
    n_tests++;
    if (any_bs !== 1'b0) begin n_fail++; $display("FAIL unlock_no_bitslip: got=1 exp 0"); end
    idle_inputs();
  endtask

  task automatic test_half_slip();
    int ln, c;
    int hs_at[$];
    bit other_hs;
    ln = $urandom_range(0, NL - 1);
    c  = $urandom_range(200, 230);
    other_hs = 1'b0;
    do_reset();
    while (m_cyc < c + 80) begin
      din_valid = (m_cyc == c || m_cyc == c + 1 || m_cyc == c + 10 || m_cyc == c + 11 ||
                   m_cyc == c + 66 || m_cyc == c + 67);
      for (int l = 0; l < NL; l++) din[l*66 +: 66] = good_word();
      if (din_valid) din[ln*66 +: 2] = 2'b00;
      tick();
      if (half_slip[ln]) hs_at.push_back(m_cyc);
      for (int l = 0; l < NL; l++) if (l != ln && half_slip[l]) other_hs = 1'b1;
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL half_slip_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
    end
    n_tests++;
    if (hs_at.size() != 2) begin
      n_fail++; $display("FAIL half_slip_count: got=%0d pulses exp 2", hs_at.size());
    end else begin
      n_tests++;
      if (hs_at[0] != c + 2 || hs_at[1] != c + 68) begin
        n_fail++; $display("FAIL half_slip_timing: got %0d,%0d exp %0d,%0d", hs_at[0], hs_at[1], c + 2, c + 68);
      end
    end
    n_tests++;
    if (other_hs !== 1'b0) begin n_fail++; $display("FAIL half_slip_other_lanes: got=1 exp 0"); end
    idle_inputs();
  endtask

  task automatic test_slip_timeout();
    do_reset();
    dec_fail = '1;
    while (m_cyc < 20490) begin
      clr_stats = (m_cyc == 10250 || m_cyc == 20479);
      tick();
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL timeout_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
      if (m_cyc == 10239 || m_cyc == 10251 || m_cyc == 20479) begin
        n_tests++;
        if (slip_timeout !== 4'h0) begin
          n_fail++; $display("FAIL timeout_clear cyc=%0d: got=%h exp 0", m_cyc, slip_timeout);
        end
      end
      if (m_cyc == 10240 || m_cyc == 10250 || m_cyc == 20480) begin
        n_tests++;
        if (slip_timeout !== 4'hF) begin
          n_fail++; $display("FAIL timeout_set cyc=%0d: got=%h exp f", m_cyc, slip_timeout);
        end
      end
      if (m_cyc == 10368) begin
        n_tests++;
        if (bitslip !== 4'hF) begin n_fail++; $display("FAIL timeout_hunt: bitslip=%h exp f", bitslip); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midlock();
    do_reset();
    while (m_cyc < 210) begin
      dec_fix[0] = (m_cyc >= 200 && m_cyc < 205);
      tick();
    end
    n_tests++;
    if (err_cnt[15:0] !== 16'd5 || wordlock !== 4'hF) begin
      n_fail++; $display("FAIL midlock_pre: cnt=%0d wl=%h exp 5/f", err_cnt[15:0], wordlock);
    end
    idle_inputs();
    arst = 1'b1;
    #1;
    n_tests++;
    if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !== '0) begin
      n_fail++;
      $display("FAIL midlock_async: outputs=%h expected 0",
               {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt});
    end
    do_reset();
    while (m_cyc < 195) begin
      tick();
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL midlock_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
      if (m_cyc >= 191 && m_cyc <= 193) begin
        n_tests++;
        if (wordlock !== ((m_cyc >= 192) ? 4'hF : 4'h0) || all_locked !== (m_cyc == 193)) begin
          n_fail++; $display("FAIL midlock_relock cyc=%0d: wl=%h all=%b", m_cyc, wordlock, all_locked);
        end
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    while (m_cyc < 4000) begin
      for (int l = 0; l < NL; l++) begin
        dec_fix[l]  = ($urandom_range(0, 299) == 0);
        dec_fail[l] = ($urandom_range(0, 999) == 0);
        din[l*66 +: 66] = ($urandom_range(0, 5) == 0) ? rand_word() : good_word();
      end
      din_valid = ($urandom_range(0, 1) == 1);
      clr_stats = ($urandom_range(0, 499) == 0);
      tick();
      n_tests++;
      if ({bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt} !==
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()}) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL random_model cyc=%0d got=%h exp=%h", m_cyc,
          {bitslip, half_slip, wordlock, all_locked, slip_timeout, err_cnt},
          {m_bs, m_hs, m_wl, m_all, m_to, exp_err()});
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_observe_slip();
    test_unlock_thresh();
    test_half_slip();
    test_slip_timeout();
    test_reset_midlock();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
